// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_pkg
// Purpose: Constants shared by the pipeline stages and the output FIFO.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Width of an occupancy counter that must be able to hold the value DEPTH.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/fifo_regfile.sv
`default_nettype none
// ============================================================================
// Module : fifo_regfile
// Purpose: DEPTH x WIDTH register array, one synchronous write port and one
//          asynchronous (combinational) read port. Contents are not reset.
// Ports  : clk      - write clock
//          wr_en    - write strobe
//          wr_addr  - write index
//          wr_data  - write word
//          rd_addr  - read index
//          rd_data  - word stored at rd_addr (combinational)
// Rev    : 1.0  initial release
// ============================================================================
module fifo_regfile
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately left out of reset; the head is qualified by
  // out_valid in the parent so stale contents are never consumed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : fifo_regfile
`default_nettype wire

// File: rtl/pipe_out_fifo.sv
`default_nettype none
// ============================================================================
// Module : pipe_out_fifo
// Purpose: Show-ahead FIFO that collects results from a pipeline output.
//          Raises stall at an almost-full level so that results already in
//          flight still find room; anything arriving while truly full (and
//          not popping) is dropped and recorded in a sticky overflow flag.
// Ports  : clk, rst          - clock, asynchronous active-high reset
//          in_valid, in_data - upstream result
//          stall             - ask upstream to stop issuing (count>=AF_LEVEL)
//          out_valid/out_data/out_ready - show-ahead consumer handshake
//          count             - current occupancy (0..DEPTH)
//          overflow          - sticky "a valid result was dropped"
// Rev    : 1.0  initial release
// ============================================================================
module pipe_out_fifo
  import pipe_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   stall,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, pop, push, drop;

  always_comb begin
    full = (count_q == FULL_CNT);
    pop  = (count_q != '0) & out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push = in_valid & (~full | pop);
    drop = in_valid & full & ~pop;

    // DEPTH is a power of two, so natural pointer wrap is the modulo.
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_ptr_q),
    .rd_data (out_data)
  );

  // Flags decode registered state only: no path from in_valid/out_ready.
  assign out_valid = (count_q != '0);
  assign stall     = (count_q >= AF_CNT);
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule : pipe_out_fifo
`default_nettype wire

// File: doc/pipe_out_fifo.md
PIPE_OUT_FIFO -- requirements
Module: pipe_out_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of pipeline results.
REQ-002 SHALL have parameter DEPTH, default 4, giving the number of entries; it is a power of two and at least 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, giving the occupancy at which stall asserts; its legal range is 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream pipeline's result on in_data is valid this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: result word from the upstream pipeline output (dataout).
REQ-008 SHALL have port stall, output, 1 bit: request to the upstream pipeline to stop issuing new operands.
REQ-009 SHALL have port out_valid, output, 1 bit: the head entry is present on out_data.
REQ-010 SHALL have port out_data, output, WIDTH bits: the head entry, show-ahead.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data this cycle.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a valid result was dropped.

Function
REQ-014 SHALL define pop = out_valid & out_ready, and SHALL define push = in_valid & (count<DEPTH | pop).
REQ-015 SHALL write in_data at the write pointer on push and advance the write pointer modulo DEPTH.
REQ-016 SHALL advance the read pointer modulo DEPTH on pop; out_data SHALL be driven combinationally from storage at the read pointer.
REQ-017 SHALL update count as count+push-pop each cycle; simultaneous push and pop SHALL leave count unchanged.
REQ-018 SHALL drive out_valid = (count!=0); a word pushed at edge N SHALL appear on out_valid/out_data after edge N (1-cycle latency, no bypass when empty).
REQ-019 SHALL drive stall = (count>=AF_LEVEL), decoded from registered count only, with no combinational path from in_valid or out_ready.
REQ-020 SHALL accept a push when full and popping in the same cycle, with no drop and no overflow.
REQ-021 SHALL, when in_valid is high, count==DEPTH and pop==0, discard in_data, leave storage and pointers unchanged, and set overflow to 1; overflow SHALL hold until rst.
REQ-022 SHALL treat out_ready while empty as no effect: pointers and count are unchanged.
REQ-023 SHALL not place stall in any internal gating: entries arriving after stall asserts (in-flight pipeline results) SHALL still be accepted while space remains.
REQ-024 SHALL preserve FIFO order across pointer wrap-around for any number of cycles.

Reset
REQ-025 SHALL, on rst asserted (asynchronously, at any time including mid-transfer), clear write/read pointers, count, overflow; outputs go to out_valid=0, stall=0 (for AF_LEVEL>=1), count=0, overflow=0.
REQ-026 SHALL not reset storage contents; out_data SHALL be don't-care while out_valid=0.
REQ-027 SHALL ignore in_valid and out_ready while rst is high; the first push is possible on the first rising edge after deassertion.

Structure
REQ-028 SHALL place constants DEFAULT_WIDTH=8 and DEFAULT_DEPTH=4 in shared package pipe_pkg, which also serves the upstream pipeline stages.
REQ-029 SHALL use one sub-module, fifo_regfile: a DEPTH x WIDTH register array with 1 synchronous write port and 1 asynchronous read port; pointer, count and flag logic SHALL live in pipe_out_fifo.
REQ-030 SHALL target an RTL size of 120-400 lines, with no latches and no multi-clock logic.

Verification
REQ-031 SHALL cover fill-to-full: rst, then push 0x11,0x22,0x33 with out_ready=0 -> stall=1 after the 3rd edge (count=3); push 0x44 -> count=4, overflow=0.
REQ-032 SHALL cover overflow: when full, push 0x55 with out_ready=0 -> 0x55 dropped, overflow=1 and stays 1; drain yields 0x11,0x22,0x33,0x44, then out_valid=0.
REQ-033 SHALL cover simultaneous push/pop at full: count=4, head 0x11, in_valid=1 with 0xAA and out_ready=1 -> 0x11 consumed, count stays 4, overflow stays 0, 0xAA is last out.
REQ-034 SHALL cover wrap-around: random 8-bit data, random in_valid/out_ready at 50% for 1000 cycles, using a scoreboard that excludes dropped words -> output order matches, count never exceeds 4.
REQ-035 SHALL cover reset mid-operation: count=3, stall=1, assert rst between edges -> out_valid=0, stall=0, count=0 immediately (before the next edge), overflow=0.
REQ-036 SHALL cover empty read: out_ready=1 with count=0 for 5 cycles -> count remains 0, no pointer movement; the next push of 0x7E appears on out_data one edge later.
